// File: rtl/universal_shift_reg.sv
// Universal shift register: parallel load/clear plus multi-cycle burst
// shifts and rotates. Each burst runs one 1-bit step per clock edge.
module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             serial_in,
    output logic             cmd_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_remaining;
    logic [WIDTH-1:0] r_data;
    logic             r_serial;
    logic             r_done;
    logic             r_busy;
    logic             r_ready;

    logic [2:0]       w_step_op;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_asr;
    logic [WIDTH-1:0] w_step_data;
    logic             w_step_serial;

    // The first step of a burst uses the incoming opcode; later steps the latched one.
    assign w_step_op = (r_state == ST_SHIFT) ? r_op : cmd_op;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (gi == 0) begin : g_lsb
            assign w_shl[gi] = serial_in;
            assign w_rol[gi] = r_data[WIDTH-1];
        end else begin : g_upper
            assign w_shl[gi] = r_data[gi-1];
            assign w_rol[gi] = r_data[gi-1];
        end
        if (gi == WIDTH-1) begin : g_msb
            assign w_shr[gi] = serial_in;
            assign w_ror[gi] = r_data[0];
            assign w_asr[gi] = r_data[WIDTH-1];
        end else begin : g_lower
            assign w_shr[gi] = r_data[gi+1];
            assign w_ror[gi] = r_data[gi+1];
            assign w_asr[gi] = r_data[gi+1];
        end
    end

    always_comb begin
        w_step_data   = r_data;
        w_step_serial = r_serial;
        case (w_step_op)
            OP_SHL: begin
                w_step_data   = w_shl;
                w_step_serial = r_data[WIDTH-1];
            end
            OP_SHR: begin
                w_step_data   = w_shr;
                w_step_serial = r_data[0];
            end
            OP_ROL: begin
                w_step_data   = w_rol;
                w_step_serial = r_data[WIDTH-1];
            end
            OP_ROR: begin
                w_step_data   = w_ror;
                w_step_serial = r_data[0];
            end
            OP_ASR: begin
                w_step_data   = w_asr;
                w_step_serial = r_data[0];
            end
            default: begin
                w_step_data   = r_data;
                w_step_serial = r_serial;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_NOP;
            r_remaining <= CNT_ZERO;
            r_data      <= '0;
            r_serial    <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (cmd_valid && r_ready) begin
                    case (cmd_op)
                        OP_NOP: begin
                        end
                        OP_LOAD: begin
                            r_data <= cmd_data;
                            r_done <= 1'b1;
                        end
                        OP_CLEAR: begin
                            r_data <= '0;
                            r_done <= 1'b1;
                        end
                        default: begin
                            if (cmd_count != CNT_ZERO) begin
                                r_data   <= w_step_data;
                                r_serial <= w_step_serial;
                            end
                            // Bursts of 0 or 1 steps finish on the accept edge.
                            if (cmd_count > CNT_ONE) begin
                                r_op        <= cmd_op;
                                r_remaining <= cmd_count - CNT_ONE;
                                r_state     <= ST_SHIFT;
                                r_busy      <= 1'b1;
                                r_ready     <= 1'b0;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    endcase
                end
            end else begin
                r_data      <= w_step_data;
                r_serial    <= w_step_serial;
                r_remaining <= r_remaining - CNT_ONE;
                if (r_remaining == CNT_ONE) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign cmd_ready  = r_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign data_out   = r_data;
    assign serial_out = r_serial;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: directed vector table, hand-written corner
// sequences and randomized commands checked against an arithmetic model.
`timescale 1ns/1ps
module tb_universal_shift_reg;

    localparam int W  = 8;
    localparam int CW = 4;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LD  = 3'd1;
    localparam logic [2:0] OP_SHL = 3'd2;
    localparam logic [2:0] OP_SHR = 3'd3;
    localparam logic [2:0] OP_ROL = 3'd4;
    localparam logic [2:0] OP_ROR = 3'd5;
    localparam logic [2:0] OP_ASR = 3'd6;
    localparam logic [2:0] OP_CLR = 3'd7;

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic [3:0] cnt;
        logic       sin;
        logic [7:0] exp_data;
        logic       exp_serial;
        int         exp_busy;
        logic       exp_done;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic [2:0]    cmd_op;
    logic [W-1:0]  cmd_data;
    logic [CW-1:0] cmd_count;
    logic          serial_in;
    logic          cmd_ready;
    logic          busy;
    logic          done;
    logic [W-1:0]  data_out;
    logic          serial_out;

    int   checks   = 0;
    int   failures = 0;
    int   mdl_data;
    logic mdl_serial;
    logic [7:0] trace[$];

    always #5 clk = ~clk;

    universal_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_count  (cmd_count),
        .serial_in  (serial_in),
        .cmd_ready  (cmd_ready),
        .busy       (busy),
        .done       (done),
        .data_out   (data_out),
        .serial_out (serial_out)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h required=%02h", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One 1-bit step of the model, expressed as integer arithmetic on the value.
    task automatic mdl_step(input logic [2:0] op, input logic sin);
        int d;
        int s;
        d = mdl_data;
        s = sin ? 1 : 0;
        case (op)
            OP_SHL: begin mdl_serial = (d / 128) != 0; mdl_data = (d * 2 + s) % 256; end
            OP_SHR: begin mdl_serial = (d % 2) != 0;   mdl_data = d / 2 + s * 128; end
            OP_ASR: begin mdl_serial = (d % 2) != 0;   mdl_data = d / 2 + (d / 128) * 128; end
            OP_ROL: begin mdl_serial = (d / 128) != 0; mdl_data = (d * 2) % 256 + d / 128; end
            OP_ROR: begin mdl_serial = (d % 2) != 0;   mdl_data = d / 2 + (d % 2) * 128; end
            default: begin end
        endcase
    endtask

    function automatic logic pick_sin(input int mode);
        if (mode == 2) return 1'($urandom_range(0, 1));
        return (mode != 0);
    endfunction

    task automatic drive_junk(input int mode);
        if (mode == 1) begin
            cmd_valid = 1'b1;
            cmd_op    = OP_LD;
            cmd_data  = 8'hFF;
        end else if (mode == 2) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_data  = 8'($urandom);
            cmd_count = 4'($urandom_range(0, 15));
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input int cycles);
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = OP_LD;
        cmd_data  = 8'h5A;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        mdl_data   = 0;
        mdl_serial = 1'b0;
        chk8("reset_data", data_out, 8'h00);
        chk1("reset_serial", serial_out, 1'b0);
        chk1("reset_done", done, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_ready", cmd_ready, 1'b1);
        reset     = 1'b0;
        cmd_valid = 1'b0;
        $display("txn reset cycles=%0d -> data_out=%02h ready=%0b", cycles, data_out, cmd_ready);
    endtask

    // Issues one command at the current negedge and follows it to its done cycle.
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] d, input logic [3:0] n,
                          input int sin_mode, input int junk_mode, input bit gap,
                          output int busy_cnt, output logic done_seen);
        int steps;
        busy_cnt = 0;
        trace.delete();
        chk1("ready_before_cmd", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_count = n;
        serial_in = pick_sin(sin_mode);
        @(posedge clk);
        steps = 0;
        if (op == OP_LD) mdl_data = int'(d);
        else if (op == OP_CLR) mdl_data = 0;
        else if (op != OP_NOP && n != 4'd0) begin
            mdl_step(op, serial_in);
            steps = int'(n) - 1;
        end
        @(negedge clk);
        while (steps > 0) begin
            trace.push_back(data_out);
            if (busy) busy_cnt++;
            chk1("burst_busy", busy, 1'b1);
            chk1("burst_ready", cmd_ready, 1'b0);
            chk1("burst_done", done, 1'b0);
            chk8("burst_data", data_out, 8'(mdl_data));
            chk1("burst_serial", serial_out, mdl_serial);
            drive_junk(junk_mode);
            serial_in = pick_sin(sin_mode);
            @(posedge clk);
            mdl_step(op, serial_in);
            steps--;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        trace.push_back(data_out);
        done_seen = done;
        chk1("final_done", done, op != OP_NOP);
        chk1("final_busy", busy, 1'b0);
        chk1("final_ready", cmd_ready, 1'b1);
        chk8("final_data", data_out, 8'(mdl_data));
        chk1("final_serial", serial_out, mdl_serial);
        $display("txn op=%0d data=%02h n=%0d -> data_out=%02h serial_out=%0b busy_cycles=%0d done=%0b",
                 op, d, n, data_out, serial_out, busy_cnt, done_seen);
        if (gap) begin
            @(posedge clk);
            @(negedge clk);
            chk1("done_one_cycle", done, 1'b0);
            chk8("idle_hold_data", data_out, 8'(mdl_data));
        end
    endtask

    vec_t       vt[16];
    logic [7:0] exp_shl[3];
    logic [7:0] exp_asr[2];
    int         bc;
    logic       ds;

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = '0;
        cmd_count = '0;
        serial_in = 1'b0;
        mdl_data  = 0;
        mdl_serial = 1'b0;

        vt[0]  = '{OP_LD,  8'hA5, 4'd0,  1'b0, 8'hA5, 1'b0, 0,  1'b1};
        vt[1]  = '{OP_SHL, 8'h00, 4'd3,  1'b1, 8'h2F, 1'b1, 2,  1'b1};
        vt[2]  = '{OP_LD,  8'h80, 4'd0,  1'b0, 8'h80, 1'b1, 0,  1'b1};
        vt[3]  = '{OP_ASR, 8'h00, 4'd2,  1'b1, 8'hE0, 1'b0, 1,  1'b1};
        vt[4]  = '{OP_LD,  8'hA5, 4'd0,  1'b0, 8'hA5, 1'b0, 0,  1'b1};
        vt[5]  = '{OP_ROR, 8'h00, 4'd8,  1'b0, 8'hA5, 1'b1, 7,  1'b1};
        vt[6]  = '{OP_LD,  8'h3C, 4'd0,  1'b0, 8'h3C, 1'b1, 0,  1'b1};
        vt[7]  = '{OP_SHL, 8'h00, 4'd0,  1'b1, 8'h3C, 1'b1, 0,  1'b1};
        vt[8]  = '{OP_NOP, 8'h77, 4'd5,  1'b1, 8'h3C, 1'b1, 0,  1'b0};
        vt[9]  = '{OP_CLR, 8'h00, 4'd0,  1'b0, 8'h00, 1'b1, 0,  1'b1};
        vt[10] = '{OP_LD,  8'hC3, 4'd0,  1'b0, 8'hC3, 1'b1, 0,  1'b1};
        vt[11] = '{OP_ROL, 8'h00, 4'd1,  1'b0, 8'h87, 1'b1, 0,  1'b1};
        vt[12] = '{OP_SHR, 8'h00, 4'd4,  1'b0, 8'h08, 1'b0, 3,  1'b1};
        vt[13] = '{OP_ROL, 8'h00, 4'd9,  1'b1, 8'h10, 1'b0, 8,  1'b1};
        vt[14] = '{OP_SHR, 8'h00, 4'd15, 1'b1, 8'hFF, 1'b1, 14, 1'b1};
        vt[15] = '{OP_ASR, 8'h00, 4'd2,  1'b0, 8'hFF, 1'b1, 1,  1'b1};
        exp_shl = '{8'h4B, 8'h97, 8'h2F};
        exp_asr = '{8'hC0, 8'hE0};

        do_reset(3);

        for (int i = 0; i < 16; i++) begin
            do_cmd(vt[i].op, vt[i].data, vt[i].cnt, vt[i].sin ? 1 : 0, 0, 1'b1, bc, ds);
            chk8($sformatf("vec%0d_data", i), data_out, vt[i].exp_data);
            chk1($sformatf("vec%0d_serial", i), serial_out, vt[i].exp_serial);
            chkn($sformatf("vec%0d_busy_cycles", i), bc, vt[i].exp_busy);
            chk1($sformatf("vec%0d_done", i), ds, vt[i].exp_done);
        end

        // Step-by-step values of a shift-left and an arithmetic-right burst.
        do_cmd(OP_LD, 8'hA5, 4'd0, 0, 0, 1'b1, bc, ds);
        do_cmd(OP_SHL, 8'h00, 4'd3, 1, 0, 1'b1, bc, ds);
        chkn("shl_trace_len", trace.size(), 3);
        for (int i = 0; i < 3; i++) chk8($sformatf("shl_step%0d", i), trace[i], exp_shl[i]);
        do_cmd(OP_LD, 8'h80, 4'd0, 0, 0, 1'b1, bc, ds);
        do_cmd(OP_ASR, 8'h00, 4'd2, 1, 0, 1'b1, bc, ds);
        chkn("asr_trace_len", trace.size(), 2);
        for (int i = 0; i < 2; i++) chk8($sformatf("asr_step%0d", i), trace[i], exp_asr[i]);
        chk1("asr_serial", serial_out, 1'b0);

        // Zero-count shift, then a LOAD attempted on every busy cycle of a burst.
        do_cmd(OP_LD, 8'h3C, 4'd0, 0, 0, 1'b1, bc, ds);
        do_cmd(OP_SHR, 8'h00, 4'd0, 1, 0, 1'b1, bc, ds);
        chk8("n0_data", data_out, 8'h3C);
        chk1("n0_done", ds, 1'b1);
        do_cmd(OP_ROR, 8'h00, 4'd4, 0, 1, 1'b1, bc, ds);
        chk8("ignored_load_data", data_out, 8'hC3);

        // Back-to-back: LOAD issued in the done cycle of a burst.
        do_cmd(OP_SHR, 8'h00, 4'd2, 0, 0, 1'b0, bc, ds);
        chk1("b2b_first_done", ds, 1'b1);
        do_cmd(OP_LD, 8'h01, 4'd0, 0, 0, 1'b1, bc, ds);
        chk8("b2b_data", data_out, 8'h01);
        chk1("b2b_second_done", ds, 1'b1);

        // Reset in the third cycle of a 5-step burst aborts it without a done pulse.
        cmd_valid = 1'b1;
        cmd_op    = OP_SHR;
        cmd_count = 4'd5;
        serial_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk1("abort_busy_before", busy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mdl_data   = 0;
        mdl_serial = 1'b0;
        chk8("abort_data", data_out, 8'h00);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_ready", cmd_ready, 1'b1);
        chk1("abort_done", done, 1'b0);
        $display("txn reset mid-burst -> data_out=%02h busy=%0b done=%0b", data_out, busy, done);
        @(posedge clk);
        @(negedge clk);
        chk1("abort_no_late_done", done, 1'b0);
        chk1("abort_still_idle", busy, 1'b0);
        do_reset(1);
        do_cmd(OP_LD, 8'h6E, 4'd0, 0, 0, 1'b1, bc, ds);
        chk8("resume_after_reset", data_out, 8'h6E);

        for (int k = 0; k < 150; k++) begin
            logic [2:0] rop;
            logic [3:0] rn;
            rop = 3'($urandom_range(0, 7));
            rn  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rn = 4'($urandom_range(0, 2));
            do_cmd(rop, 8'($urandom), rn, 2, 2, 1'($urandom_range(0, 1)), bc, ds);
            if ($urandom_range(0, 24) == 0) do_reset(1 + $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (minimum 2).
REQ-002 Parameter CNT_W, default 4, width of the burst shift count.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_op  input  3  opcode: 000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 CLEAR.
REQ-007 cmd_data  input  WIDTH  parallel load value, used by LOAD only.
REQ-008 cmd_count  input  CNT_W  number of 1-bit shift steps, used by shift/rotate ops only.
REQ-009 serial_in  input  1  fill bit, sampled on every SHL/SHR step edge.
REQ-010 cmd_ready  output  1  block can accept a command.
REQ-011 busy  output  1  multi-cycle burst in progress.
REQ-012 done  output  1  single-cycle completion pulse.
REQ-013 data_out  output  WIDTH  register contents.
REQ-014 serial_out  output  1  last bit shifted or rotated out.

Function
REQ-015 A command SHALL be accepted on a posedge where cmd_valid and cmd_ready are both 1; cmd_valid with cmd_ready=0 SHALL be ignored, with no queuing.
REQ-016 The FSM SHALL have two states: IDLE (cmd_ready=1, busy=0) and SHIFT (cmd_ready=0, busy=1).
REQ-017 LOAD SHALL write data_out <= cmd_data on the accept edge, stay in IDLE, and pulse done in the next cycle.
REQ-018 CLEAR SHALL write data_out <= 0 on the accept edge, stay in IDLE, and pulse done in the next cycle.
REQ-019 NOP SHALL be accepted with no state change and no done pulse.
REQ-020 Shift-class ops (SHL, SHR, ROL, ROR, ASR) SHALL perform exactly cmd_count 1-bit steps, one per edge, with the first step on the accept edge.
REQ-021 On a shift-class accept with N>=2, op and remaining=N-1 SHALL be latched and the FSM SHALL enter SHIFT.
REQ-022 Each SHIFT-state edge SHALL perform one step and decrement remaining; the edge that takes remaining to 0 SHALL return to IDLE.
REQ-023 done SHALL be 1 in the cycle after the final step edge, and cmd_ready SHALL also be 1 in that cycle, so a back-to-back command is accepted while done=1.
REQ-024 With N=1, the block SHALL stay in IDLE and pulse done in the next cycle.
REQ-025 With N=0, data_out and serial_out SHALL be unchanged, the block SHALL stay in IDLE, and done SHALL pulse in the next cycle.
REQ-026 A burst of N occupies N edges; busy SHALL be high for N-1 cycles.
REQ-027 SHL step: data_out <= {data_out[WIDTH-2:0], serial_in}; serial_out <= old MSB.
REQ-028 SHR step: data_out <= {serial_in, data_out[WIDTH-1:1]}; serial_out <= old LSB.
REQ-029 ASR step: data_out <= {MSB, data_out[WIDTH-1:1]}; serial_out <= old LSB.
REQ-030 ROL step: old MSB moves to the LSB and serial_out <= old MSB; ROR step: old LSB moves to the MSB and serial_out <= old LSB; serial_in is ignored.
REQ-031 N >= WIDTH SHALL be legal; steps continue modulo nothing (for example, ROR with N=WIDTH restores the original value).
REQ-032 LOAD, CLEAR and NOP SHALL leave serial_out unchanged.
REQ-033 done SHALL never be high for two consecutive cycles unless two commands completed back-to-back.

Reset
REQ-034 While reset=1 at a posedge, the block SHALL set data_out=0, serial_out=0, done=0, busy=0, remaining=0, state=IDLE, and cmd_ready=1 from the next cycle.
REQ-035 Reset SHALL take priority over any command or step on the same edge.
REQ-036 Reset mid-burst SHALL abort the burst with no done pulse.
REQ-037 Command acceptance SHALL resume on the first edge after reset deasserts.

Verification
REQ-038 Reset, then LOAD 8'hA5 -> data_out=8'hA5 one cycle later, done=1 for exactly one cycle, serial_out=0.
REQ-039 From 8'hA5, SHL N=3 with serial_in=1 -> data_out 8'h4B, 8'h97, 8'h2F on successive edges; busy=1 for 2 cycles; final serial_out=1; done one cycle after the third edge.
REQ-040 From 8'h80, ASR N=2 -> 8'hC0 then 8'hE0, serial_out=0; then ROR N=8 from 8'hA5 -> data_out=8'hA5 after 8 edges, done pulse.
REQ-041 Accept SHR N=5, assert reset on the 3rd cycle -> data_out=0, busy=0, cmd_ready=1, no done pulse.
REQ-042 Shift N=0 on 8'h3C -> data_out stays 8'h3C, done one cycle later; LOAD 8'hFF issued while busy=1 -> ignored, data_out unaffected.
REQ-043 Issue LOAD 8'h01 in the done cycle of a prior burst -> accepted, data_out=8'h01 next cycle, second done pulse immediately follows.
